multicycle_main_ctrl: RTL and testbench
=======================================

Name: multicycle_main_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core. It is the upstream producer of the 2-bit ALUOp code that the ALU decoder consumes.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction from the 7-bit opcode.
- Drives the datapath mux selects and write enables; combines the ALU zero flag into PCWrite for beq.
- Sits beside the ALU decoder and the immediate extender in the control path.

Parameters:
- ST_W, 4, width of the state register.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] taken from the instruction register.
- zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable; equals PCUpdate | (Branch & zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  ALU operation class: 00 = add, 01 = I-type by funct3, 10 = R-type by funct3/funct7, 11 = subtract (compare).
- retire  out  1  one-cycle pulse on the final cycle of each legal instruction.

Behaviour:
- Moore FSM. All outputs decode from the state, except PCWrite, which also uses zero. Any output not listed for a state is 0.
- States and their outputs:
  - FETCH(0): AdrSrc=0, IRWrite=1, A=00, B=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE(1): A=01, B=01, ALUOp=00. Computes the branch target into ALUOut.
  - MEMADR(2): A=10, B=01, ALUOp=00.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00.
  - MEMWB(4): ResultSrc=01, RegWrite=1, retire=1.
  - MEMWRITE(5): AdrSrc=1, MemWrite=1, retire=1.
  - EXECR(6): A=10, B=00, ALUOp=10.
  - EXECI(8): A=10, B=01, ALUOp=01.
  - ALUWB(7): ResultSrc=00, RegWrite=1, retire=1.
  - JAL(9): A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ(10): A=10, B=00, ALUOp=11, ResultSrc=00, Branch=1, retire=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> illegal handling (see Optional Feature).
  - MEMADR: op == 0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR, EXECI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Latency in cycles, FETCH to retire inclusive: lw 5; sw, R-type, I-type and jal 4; beq 3.
- beq: PCWrite=1 in BEQ only when zero=1; the PC then loads the DECODE-computed target from ALUOut.
- op is sampled only in DECODE and MEMADR. The IR is stable because IRWrite=1 only in FETCH.
- Reset:
  - While rst=1, state=FETCH and every output is forced to 0, including PCWrite, IRWrite and retire.
  - Assertion is asynchronous and may occur mid-instruction with no partial writes afterwards.
  - The first cycle after rst deassertion is FETCH with normal FETCH outputs.
- Unused state codes (11 when the feature is off, 12-15) -> FETCH on the next edge, all outputs 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Extra state TRAP(11) and extra output port illegal_op (1 bit).
  - An unknown opcode in DECODE -> TRAP. TRAP is sticky until rst, drives all outputs 0, and holds illegal_op=1.
- Undefined:
  - An unknown opcode in DECODE -> FETCH and executes as a 2-cycle NOP with retire=0.
  - No illegal_op port exists.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ;
  - ALUOp codes ALUOP_ADD, ALUOP_ITYPE, ALUOP_RTYPE, ALUOP_SUB;
  - the ResultSrc, ALUSrcA and ALUSrcB encodings;
  - the state codes.
- The ALU decoder also imports the ALUOp codes from this package.
- One natural sub-module: ctrl_out_decode, the combinational state-to-output table. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> all outputs 0, state 0. Release rst -> IRWrite=1, PCWrite=1, ALUSrcB=10 in the first cycle.
- lw (op=0000011) -> state sequence 0,1,2,3,4; AdrSrc=1 in MEMREAD; RegWrite=1 with ResultSrc=01 in cycle 5; retire in cycle 5 only.
- R-type (0110011), then I-type (0010011) -> ALUOp=10 in EXECR and ALUOp=01 in EXECI; each instruction takes 4 cycles.
- beq (1100011): with zero=1 -> PCWrite=1 in cycle 3, ALUOp=11. With zero=0 -> PCWrite=0 and the next cycle is FETCH.
- jal (1101111) -> PCWrite=1 with A=01 and B=10 in JAL, then RegWrite=1 in ALUWB.
- Illegal op 1111111:
  - feature off -> returns to FETCH after DECODE, retire never pulses.
  - feature on -> illegal_op=1 and stays in TRAP for 10 cycles until rst.
- Additional case: rst asserted during MEMWRITE -> MemWrite drops to 0 immediately (asynchronously).

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared control-path definitions for the multi-cycle RV32I core.
// Holds the opcode constants, the ALUOp class codes (also used by the ALU
// decoder), the datapath mux encodings, the main FSM state codes and the
// bundle of control outputs produced by the state decoder.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the illegal flag to ctrl_t).
package rv_ctrl_pkg;

    localparam int CTRL_ST_W = 4;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOp classes consumed by the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [CTRL_ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
`ifdef ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_ctrl_if.sv
// Control bundle between the main FSM and the datapath.
// master: the controller (takes op/zero, drives every control line).
// slave : the datapath side (drives op/zero, receives the control lines).
// Optional feature macro: ILLEGAL_TRAP_EN (adds illegal_op).
interface multicycle_main_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       retire;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    modport master (
        input  op, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire
`ifdef ILLEGAL_TRAP_EN
        , output illegal_op
`endif
    );

    modport slave (
        output op, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire
`ifdef ILLEGAL_TRAP_EN
        , input illegal_op
`endif
    );
endinterface

// File: rtl/multicycle_main_ctrl_out_decode.sv
// ctrl_out_decode: combinational Moore table from FSM state to control lines.
// Ports: state (current FSM state), zero (ALU zero flag, only used for the
// beq PCWrite term), ctrl (decoded control bundle).
// Unused state codes (and TRAP) decode to all zeros.
// Optional feature macro: ILLEGAL_TRAP_EN (TRAP raises ctrl.illegal).
module ctrl_out_decode
    import rv_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    output ctrl_t  ctrl
);
    logic pc_update;
    logic branch;

    always_comb begin
        ctrl      = '0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                pc_update       = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_READDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_JAL: begin
                // PC+4 goes to ALUOut for the link; PC loads the target from ALUOut
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                pc_update       = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                branch          = 1'b1;
                ctrl.retire     = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        ctrl.pc_write = pc_update | (branch & zero);
    end
endmodule

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: main control FSM of the multi-cycle RV32I core.
// Ports: clk (rising edge), rst (async, active high), bus (master modport of
// multicycle_main_ctrl_if: op/zero in, datapath controls and retire out).
// Parameter ST_W: state register width.
// While rst is high the state is FETCH and every output is forced low.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode -> sticky TRAP
// with illegal_op=1; otherwise an unknown opcode is a silent 2-cycle NOP).
module multicycle_main_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int ST_W = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_main_ctrl_if.master bus
);
    logic [ST_W-1:0] state_reg;
    state_t          cur_state;
    state_t          next_state;
    ctrl_t           ctrl_raw;
    ctrl_t           ctrl_out;

    assign cur_state = state_t'(state_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_W'(S_FETCH);
        end else begin
            state_reg <= ST_W'(next_state);
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      next_state = S_TRAP;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:    next_state = S_TRAP;
`endif
            default:   next_state = S_FETCH;
        endcase
    end

    ctrl_out_decode u_out_decode (
        .state (cur_state),
        .zero  (bus.zero),
        .ctrl  (ctrl_raw)
    );

    // Combinational gate so outputs drop the instant rst rises, even
    // before the state register has been cleared.
    assign ctrl_out = rst ? '0 : ctrl_raw;

    assign bus.PCWrite   = ctrl_out.pc_write;
    assign bus.AdrSrc    = ctrl_out.adr_src;
    assign bus.MemWrite  = ctrl_out.mem_write;
    assign bus.IRWrite   = ctrl_out.ir_write;
    assign bus.RegWrite  = ctrl_out.reg_write;
    assign bus.ResultSrc = ctrl_out.result_src;
    assign bus.ALUSrcA   = ctrl_out.alu_src_a;
    assign bus.ALUSrcB   = ctrl_out.alu_src_b;
    assign bus.ALUOp     = ctrl_out.alu_op;
    assign bus.retire    = ctrl_out.retire;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_op = ctrl_out.illegal;
`endif
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
module tb_multicycle_main_ctrl;
    import rv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   idx   = 0;

    multicycle_main_ctrl_if bus();

    multicycle_main_ctrl #(.ST_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observed vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,A,B,ALUOp,retire}
    logic [13:0] obs;
    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.retire};

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
    int          len_tab [7] = '{5, 4, 4, 4, 4, 3, 2};
    logic [6:0]  op_tab  [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    function automatic logic [13:0] mk(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                       logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                       logic [1:0] aop, logic ret);
        return {pcw, adr, mw, irw, rw, res, a, b, aop, ret};
    endfunction

    // Expected controls for cycle cyc (0 = fetch) of an instruction of class cls
    function automatic logic [13:0] expected(int cls, int cyc, logic z);
        logic [13:0] wb;
        wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        if (cyc == 0) return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
        if (cyc == 1) return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);
        case (cls)
            0: begin
                if (cyc == 2) return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
                if (cyc == 3) return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
            end
            1: begin
                if (cyc == 2) return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
                return mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
            end
            2: return (cyc == 2) ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0) : wb;
            3: return (cyc == 2) ? mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0) : wb;
            4: return (cyc == 2) ? mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0) : wb;
            5: return mk(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b11, 1'b1);
            default: return '0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] observed, logic [31:0] required);
        tests++;
        assert (observed === required) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, required);
        end
    endtask

    function automatic logic [6:0] illegal_op_val();
        logic [6:0] v;
        do begin
            v = 7'($urandom);
        end while (v == OP_LW || v == OP_SW || v == OP_R || v == OP_I || v == OP_JAL || v == OP_BEQ);
        return v;
    endfunction

    // Runs ncyc cycles of one instruction; checks every cycle at negedge+1.
    // zmode < 0 randomizes zero each cycle, otherwise holds it at zmode.
    task automatic run_instr(int cls, logic [6:0] opc, int ncyc, int zmode);
        logic z;
        int   rets;
        rets = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.zero = z;
            // During fetch the IR still holds the previous instruction
            bus.op = (c == 0) ? 7'($urandom) : opc;
            #1;
            check($sformatf("i%0d_cls%0d_cyc%0d", idx, cls, c), 32'(obs), 32'(expected(cls, c, z)));
            if (bus.retire) rets++;
        end
        $display("[TB] instr %0d cls=%0d op=%b cycles=%0d retires=%0d", idx, cls, opc, ncyc, rets);
        idx++;
    endtask

    initial begin
        int cls;
        bus.op   = 7'b0;
        bus.zero = 1'b1;

        // Reset held for 3 cycles: outputs and state all zero
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'(obs), 32'h0);
        check("reset_state", 32'(dut.state_reg), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed: lw, sw, R, I, jal, beq taken, beq not taken
        run_instr(0, OP_LW, 5, -1);
        run_instr(1, OP_SW, 4, -1);
        run_instr(2, OP_R, 4, -1);
        run_instr(3, OP_I, 4, -1);
        run_instr(4, OP_JAL, 4, -1);
        run_instr(5, OP_BEQ, 3, 1);
        run_instr(5, OP_BEQ, 3, 0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(6, 7'b1111111, 2, -1);
`endif

        // Reset asserted during MEMWRITE: MemWrite drops without a clock edge
        run_instr(1, OP_SW, 4, -1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_memwrite", 32'(bus.MemWrite), 32'h0);
        check("async_rst_outputs", 32'(obs), 32'h0);
        @(negedge clk);
        #1;
        check("rst_hold_state", 32'(dut.state_reg), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
            cls = $urandom_range(0, 5);
`else
            cls = $urandom_range(0, 6);
`endif
            run_instr(cls, (cls == 6) ? illegal_op_val() : op_tab[cls], len_tab[cls], -1);
        end

`ifdef ILLEGAL_TRAP_EN
        // Trap: sticky, all outputs zero, illegal_op high until reset
        run_instr(6, 7'b1111111, 2, -1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            bus.op = 7'($urandom);
            bus.zero = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("trap_outputs_%0d", t), 32'(obs), 32'h0);
            check($sformatf("trap_flag_%0d", t), 32'(bus.illegal_op), 32'h1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("trap_flag_reset", 32'(bus.illegal_op), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(2, OP_R, 4, -1);
`else
        // Closing fetch check confirms the last instruction returned to FETCH
        run_instr(5, OP_BEQ, 1, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
